// File: rtl/tone_pkg.sv
// Shared types and constants for the tone sequencer: FSM states, note table entry, half-periods.
// Latency: n/a (package). Backpressure: n/a.
package tone_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        PLAY = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int HP_W  = 20;
    localparam int DUR_W = 3;

    localparam logic [HP_W-1:0] HP_REST = 20'd0;
    localparam logic [HP_W-1:0] HP_C5   = 20'd47778;
    localparam logic [HP_W-1:0] HP_F5   = 20'd35793;
    localparam logic [HP_W-1:0] HP_G5   = 20'd31888;
    localparam logic [HP_W-1:0] HP_A5   = 20'd28409;
    localparam logic [HP_W-1:0] HP_C6   = 20'd23889;
    localparam logic [HP_W-1:0] HP_F6   = 20'd17896;

    typedef struct packed {
        logic [HP_W-1:0]  hp;
        logic [DUR_W-1:0] dur;
        logic             last;
    } entry_t;

    function automatic entry_t mk_entry(logic [HP_W-1:0] hp, logic [DUR_W-1:0] dur, logic last);
        entry_t e;
        e.hp   = hp;
        e.dur  = dur;
        e.last = last;
        return e;
    endfunction

endpackage

// File: rtl/tone_rom.sv
// Melody table: one entry per {melody, note_idx}.
// Latency: 1 cycle (registered read).
// Backpressure: none; reads every cycle.
module tone_rom
    import tone_pkg::*;
#(
    parameter int NUM_MELODIES = 4,
    parameter int MAX_NOTES    = 8
) (
    input  logic                            CLOCK_50,
    input  logic                            reset,
    input  logic [$clog2(NUM_MELODIES)-1:0] melody,
    input  logic [$clog2(MAX_NOTES)-1:0]    note_idx,
    output entry_t                          entry
);

    // Unlisted slots read as a one-slot terminating rest so a stray index always ends cleanly.
    function automatic entry_t lookup(int m, int n);
        entry_t e;
        e = mk_entry(HP_REST, 3'd1, 1'b1);
        case (m)
            0: begin
                case (n)
                    0: e = mk_entry(HP_C5, 3'd1, 1'b0);
                    1: e = mk_entry(HP_C5, 3'd1, 1'b0);
                    2: e = mk_entry(HP_F5, 3'd1, 1'b0);
                    3: e = mk_entry(HP_F5, 3'd1, 1'b0);
                    4: e = mk_entry(HP_G5, 3'd1, 1'b0);
                    5: e = mk_entry(HP_A5, 3'd1, 1'b0);
                    6: e = mk_entry(HP_C6, 3'd1, 1'b0);
                    7: e = mk_entry(HP_F6, 3'd1, 1'b1);
                    default: ;
                endcase
            end
            1: begin
                case (n)
                    0: e = mk_entry(20'd3, 3'd2, 1'b0);
                    1: e = mk_entry(HP_REST, 3'd1, 1'b0);
                    2: e = mk_entry(20'd5, 3'd0, 1'b1);
                    default: ;
                endcase
            end
            2: e = mk_entry(20'd2, 3'd1, 1'b0);
            3: if (n == 0) e = mk_entry(20'd4, 3'd3, 1'b1);
            default: ;
        endcase
        return e;
    endfunction

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            entry <= '0;
        end else begin
            entry <= lookup(int'(melody), int'(note_idx));
        end
    end

endmodule

// File: rtl/tone_sequencer.sv
// Multi-melody square-wave tone sequencer for the audio DAC port; optional TONE_GAP_EN adds silent gaps.
// Latency: start -> first sample 2 cycles; each note 1 + dur*SLOT_TICKS cycles (+GAP_TICKS gap).
// Backpressure: none; timing runs freely and samples are dropped while audio_out_allowed is low.
module tone_sequencer
    import tone_pkg::*;
#(
    parameter int CLK_FREQ     = 50000000,
    parameter int NUM_MELODIES = 4,
    parameter int MAX_NOTES    = 8,
    parameter int SAMPLE_W     = 32,
    parameter int AMPLITUDE    = 10000000,
    parameter int SLOT_TICKS   = CLK_FREQ / 8,
    parameter int GAP_TICKS    = CLK_FREQ / 100
) (
    input  logic                            CLOCK_50,
    input  logic                            reset,
    input  logic                            start,
    input  logic [$clog2(NUM_MELODIES)-1:0] melody_sel,
    input  logic                            audio_out_allowed,
    output logic                            write_audio_out,
    output logic [SAMPLE_W-1:0]             left_channel_audio_out,
    output logic [SAMPLE_W-1:0]             right_channel_audio_out,
    output logic                            busy,
    output logic                            done,
    output logic [$clog2(MAX_NOTES)-1:0]    note_idx
);

    localparam int MEL_W  = $clog2(NUM_MELODIES);
    localparam int IDX_W  = $clog2(MAX_NOTES);
    localparam int TICK_W = $clog2(SLOT_TICKS + 1);

    localparam logic [SAMPLE_W-1:0] AMP_POS   = SAMPLE_W'(AMPLITUDE);
    localparam logic [SAMPLE_W-1:0] AMP_NEG   = -AMP_POS;
    localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(SLOT_TICKS - 1);
    localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(MAX_NOTES - 1);

    if (NUM_MELODIES < 2 || MAX_NOTES < 2 || SLOT_TICKS < 1 || GAP_TICKS < 1 ||
        CLK_FREQ < 1 || SAMPLE_W < 2) begin : g_param_check
        $error("tone_sequencer: invalid parameter set");
    end

    state_t             state;
    logic [MEL_W-1:0]   melody;
    logic [HP_W-1:0]    hp;
    logic [HP_W-1:0]    hp_cnt;
    logic [DUR_W-1:0]   slot_cnt;
    logic [TICK_W-1:0]  tick_cnt;
    logic               phase;
    logic               last;
    logic [SAMPLE_W-1:0] sample;

    entry_t             rom_entry;
    logic [MEL_W-1:0]   rom_mel;
    logic [IDX_W-1:0]   rom_idx;

    logic tick_wrap;
    logic hp_wrap;
    logic note_end;
    logic final_note;

    assign tick_wrap  = (tick_cnt == TICK_LAST);
    assign hp_wrap    = (hp != HP_REST) && (hp_cnt == hp - HP_W'(1));
    assign note_end   = (state == PLAY) && tick_wrap && (slot_cnt == '0);
    assign final_note = last || (note_idx == IDX_LAST);

    // ROM address looks one cycle ahead so the entry is ready in LOAD.
    assign rom_mel = (state == IDLE) ? melody_sel : melody;
    always_comb begin
        rom_idx = note_idx;
        if (state == IDLE) begin
            rom_idx = '0;
        end else if (note_end) begin
            rom_idx = note_idx + IDX_W'(1);
        end
    end

    tone_rom #(
        .NUM_MELODIES (NUM_MELODIES),
        .MAX_NOTES    (MAX_NOTES)
    ) u_rom (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .melody   (rom_mel),
        .note_idx (rom_idx),
        .entry    (rom_entry)
    );

`ifdef TONE_GAP_EN
    localparam int GAP_W = $clog2(GAP_TICKS + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);
    logic [GAP_W-1:0] gap_cnt;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            gap_cnt <= '0;
        end else if (state == GAP) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
        end else begin
            gap_cnt <= '0;
        end
    end
`endif

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state    <= IDLE;
            melody   <= '0;
            note_idx <= '0;
            hp       <= '0;
            last     <= 1'b0;
            slot_cnt <= '0;
            tick_cnt <= '0;
            hp_cnt   <= '0;
            phase    <= 1'b0;
            sample   <= '0;
            done     <= 1'b0;
        end else begin
            done   <= 1'b0;
            sample <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        melody   <= melody_sel;
                        note_idx <= '0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    hp       <= rom_entry.hp;
                    last     <= rom_entry.last;
                    slot_cnt <= (rom_entry.dur == '0) ? '0 : rom_entry.dur - DUR_W'(1);
                    tick_cnt <= '0;
                    hp_cnt   <= '0;
                    phase    <= 1'b1;
                    sample   <= (rom_entry.hp != HP_REST) ? AMP_POS : '0;
                    state    <= PLAY;
                end
                PLAY: begin
                    tick_cnt <= tick_wrap ? '0 : tick_cnt + TICK_W'(1);
                    if (tick_wrap && slot_cnt != '0) begin
                        slot_cnt <= slot_cnt - DUR_W'(1);
                    end
                    if (hp_wrap) begin
                        hp_cnt <= '0;
                        phase  <= ~phase;
                    end else if (hp != HP_REST) begin
                        hp_cnt <= hp_cnt + HP_W'(1);
                    end
                    if (note_end) begin
                        if (final_note) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            note_idx <= note_idx + IDX_W'(1);
`ifdef TONE_GAP_EN
                            state    <= GAP;
`else
                            state    <= LOAD;
`endif
                        end
                    end else if (hp != HP_REST) begin
                        // Sample tracks the phase value that this edge produces.
                        sample <= (phase ^ hp_wrap) ? AMP_POS : AMP_NEG;
                    end
                end
`ifdef TONE_GAP_EN
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= LOAD;
                    end
                end
`endif
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy                    = (state != IDLE);
    assign write_audio_out         = audio_out_allowed & ((state == PLAY) | (state == GAP));
    assign left_channel_audio_out  = sample;
    assign right_channel_audio_out = sample;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: table of melody runs plus randomized runs against a note-level model.
module tb_tone_sequencer;

    localparam int SLOT = 10;
    localparam int GAPT = 4;
    localparam int AMP  = 10000000;
    localparam int NM   = 4;
    localparam int MN   = 8;
`ifdef TONE_GAP_EN
    localparam int GAP = GAPT;
`else
    localparam int GAP = 0;
`endif

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  melody_sel = 2'd0;
    logic        audio_out_allowed = 1'b1;
    logic        write_audio_out;
    logic [31:0] left_channel_audio_out;
    logic [31:0] right_channel_audio_out;
    logic        busy;
    logic        done;
    logic [2:0]  note_idx;

    always #5 CLOCK_50 = ~CLOCK_50;

    tone_sequencer #(
        .CLK_FREQ     (800),
        .NUM_MELODIES (NM),
        .MAX_NOTES    (MN),
        .SAMPLE_W     (32),
        .AMPLITUDE    (AMP),
        .SLOT_TICKS   (SLOT),
        .GAP_TICKS    (GAPT)
    ) dut (
        .CLOCK_50                (CLOCK_50),
        .reset                   (reset),
        .start                   (start),
        .melody_sel              (melody_sel),
        .audio_out_allowed       (audio_out_allowed),
        .write_audio_out         (write_audio_out),
        .left_channel_audio_out  (left_channel_audio_out),
        .right_channel_audio_out (right_channel_audio_out),
        .busy                    (busy),
        .done                    (done),
        .note_idx                (note_idx)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Melody contents as the test ROM defines them.
    int mel_hp   [NM][MN];
    int mel_dur  [NM][MN];
    bit mel_last [NM][MN];

    typedef struct {
        bit busy;
        bit done;
        bit play;
        int idx;
        int smp;
    } exp_t;

    exp_t trace[$];

    function automatic exp_t ex(bit b, bit d, bit p, int idx, int s);
        exp_t e;
        e.busy = b;
        e.done = d;
        e.play = p;
        e.idx  = idx;
        e.smp  = s;
        return e;
    endfunction

    function automatic int smp_of(int hp, int k);
        if (hp == 0) return 0;
        return ((k / hp) % 2 == 0) ? AMP : -AMP;
    endfunction

    // Expected per-cycle outputs from the cycle after start is sampled through the done cycle.
    task automatic build_trace(input int m);
        int d;
        bit fin;
        trace.delete();
        for (int i = 0; i < MN; i++) begin
            d   = (mel_dur[m][i] == 0) ? 1 : mel_dur[m][i];
            fin = mel_last[m][i] || (i == MN - 1);
            trace.push_back(ex(1'b1, 1'b0, 1'b0, i, 0));
            for (int k = 0; k < d * SLOT; k++)
                trace.push_back(ex(1'b1, 1'b0, 1'b1, i, smp_of(mel_hp[m][i], k)));
            if (fin) begin
                trace.push_back(ex(1'b1, 1'b1, 1'b0, i, 0));
                break;
            end
            for (int g = 0; g < GAP; g++)
                trace.push_back(ex(1'b1, 1'b0, 1'b1, i + 1, 0));
        end
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        chk({tag, "_busy"}, longint'(busy), longint'(e.busy));
        chk({tag, "_done"}, longint'(done), longint'(e.done));
        chk({tag, "_idx"}, longint'(note_idx), longint'(e.idx));
        chk({tag, "_left"}, longint'($signed(left_channel_audio_out)), longint'(e.smp));
        chk({tag, "_right"}, longint'($signed(right_channel_audio_out)), longint'(e.smp));
        chk({tag, "_write"}, longint'(write_audio_out), longint'(audio_out_allowed & e.play));
    endtask

    // mode: 0 allowed held high, 1 allowed toggles every cycle, 2 allowed random.
    task automatic run_melody(input int m, input int mode, input int exp_len);
        int done_at;
        int n_done;
        done_at = -1;
        n_done  = 0;
        build_trace(m);
        @(posedge CLOCK_50); #1;
        start = 1'b1;
        melody_sel = 2'(m);
        audio_out_allowed = 1'b1;
        #1;
        chk("idle_before_start", longint'(busy), 0);
        for (int c = 0; c < trace.size(); c++) begin
            @(posedge CLOCK_50); #1;
            start = 1'($urandom_range(0, 1));
            melody_sel = 2'($urandom);
            case (mode)
                0: audio_out_allowed = 1'b1;
                1: audio_out_allowed = c[0];
                default: audio_out_allowed = 1'($urandom_range(0, 1));
            endcase
            #1;
            check_outputs("play", trace[c]);
            if (done) begin
                n_done++;
                done_at = c + 1;
            end
        end
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        audio_out_allowed = 1'b1;
        #1;
        chk("idle_after_busy", longint'(busy), 0);
        chk("idle_after_done", longint'(done), 0);
        chk("idle_after_write", longint'(write_audio_out), 0);
        chk("done_pulse_count", longint'(n_done), 1);
        if (exp_len >= 0) chk("melody_length", longint'(done_at), longint'(exp_len));
    endtask

    typedef struct {
        int mel;
        int mode;
        int len;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int hp0[MN];
        int n_done;
        hp0 = '{47778, 47778, 35793, 35793, 31888, 28409, 23889, 17896};
        for (int m = 0; m < NM; m++)
            for (int n = 0; n < MN; n++) begin
                mel_hp[m][n] = 0; mel_dur[m][n] = 1; mel_last[m][n] = 1'b1;
            end
        for (int n = 0; n < MN; n++) begin
            mel_hp[0][n] = hp0[n]; mel_dur[0][n] = 1; mel_last[0][n] = (n == MN - 1);
            mel_hp[2][n] = 2;      mel_dur[2][n] = 1; mel_last[2][n] = 1'b0;
        end
        mel_hp[1][0] = 3; mel_dur[1][0] = 2; mel_last[1][0] = 1'b0;
        mel_hp[1][1] = 0; mel_dur[1][1] = 1; mel_last[1][1] = 1'b0;
        mel_hp[1][2] = 5; mel_dur[1][2] = 0; mel_last[1][2] = 1'b1;
        mel_hp[3][0] = 4; mel_dur[3][0] = 3; mel_last[3][0] = 1'b1;

        // Cycles from the start-sampling edge to the done cycle, worked out by hand.
        vecs[0] = '{0, 0, 8 * (SLOT + 1) + 1 + 7 * GAP};
        vecs[1] = '{1, 0, (2 * SLOT + 1) + 2 * (SLOT + 1) + 1 + 2 * GAP};
        vecs[2] = '{1, 1, (2 * SLOT + 1) + 2 * (SLOT + 1) + 1 + 2 * GAP};
        vecs[3] = '{2, 2, 8 * (SLOT + 1) + 1 + 7 * GAP};
        vecs[4] = '{3, 1, 3 * SLOT + 2};
        vecs[5] = '{0, 1, 8 * (SLOT + 1) + 1 + 7 * GAP};

        // Reset with start held high must leave everything idle and zero.
        start = 1'b1;
        audio_out_allowed = 1'b1;
        repeat (3) @(posedge CLOCK_50);
        #1;
        check_outputs("reset", ex(1'b0, 1'b0, 1'b0, 0, 0));
        reset = 1'b0;
        start = 1'b0;

        foreach (vecs[i]) run_melody(vecs[i].mel, vecs[i].mode, vecs[i].len);

        for (int r = 0; r < 6; r++)
            run_melody(int'($urandom_range(0, NM - 1)), int'($urandom_range(0, 2)), -1);

        // Reset in the middle of note 3: no done pulse may follow.
        build_trace(0);
        @(posedge CLOCK_50); #1;
        start = 1'b1;
        melody_sel = 2'd0;
        for (int c = 0; c < 3 * (SLOT + 1 + GAP) + 5; c++) begin
            @(posedge CLOCK_50); #1;
            start = 1'($urandom_range(0, 1));
            #1;
            check_outputs("pre_reset", trace[c]);
        end
        chk("pre_reset_note3", longint'(note_idx), 3);
        reset = 1'b1;
        start = 1'b1;
        @(posedge CLOCK_50); #1;
        start = 1'b0;
        #1;
        check_outputs("mid_reset", ex(1'b0, 1'b0, 1'b0, 0, 0));
        reset = 1'b0;
        n_done = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge CLOCK_50); #1;
            if (done) n_done++;
            chk("post_reset_busy", longint'(busy), 0);
        end
        chk("post_reset_done_count", longint'(n_done), 0);
        run_melody(3, 0, 3 * SLOT + 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
